// File: rtl/cnn_pkg.sv
// Shared CNN datapath types and helpers used by conv_layer and maxpool_2x2.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package cnn_pkg;

  // Default activation width shared by the conv and pooling stages
  localparam int DATA_W_DEF = 16;

  // One signed activation at the default width
  typedef logic signed [DATA_W_DEF-1:0] act_t;

  // Signed maximum; ties return the shared value
  function automatic act_t smax(input act_t a, input act_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding the horizontal pair maxima of an even row.
// Latency: write lands on the clock edge; read is combinational.
// Backpressure: none; the caller gates the write enable with its handshake.
module pool_line_buf #(
  parameter int DEPTH  = 13,
  parameter int DATA_W = 16,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  // No reset: every entry is written on an even row before the odd row reads it
  logic [DATA_W-1:0] mem [DEPTH];

  // Single write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-order feature map.
// Latency: pooled pixel is valid the cycle after the odd-row, odd-col input beat.
// Backpressure: input stalls (in_ready_o low) while a pooled pixel is held unaccepted.
module maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  input  logic signed [DATA_W-1:0] in_data_i,
  output logic                     in_ready_o,
  output logic                     out_valid_o,
  output logic signed [DATA_W-1:0] out_data_o,
  input  logic                     out_ready_i,
  output logic                     out_last_o,
  output logic                     done_o
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LB_D  = IMG_W / 2;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

  typedef logic signed [DATA_W-1:0] pix_t;

  // Signed maximum at this instance's width
  function automatic pix_t max_s(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  pix_t             h;
  pix_t             m;
  pix_t             pooled;
  logic [DATA_W-1:0] lb_rdata;
  logic [LB_AW-1:0] lb_addr;
  logic             in_acc;
  logic             out_acc;
  logic             col_end;
  logic             row_end;
  logic             lb_we;
  logic             load_out;

  // One stall rule for every row and column: accept input only if the output slot frees up
  assign in_ready_o = !out_valid_o || out_ready_i;
  assign in_acc     = in_valid_i && in_ready_o;
  assign out_acc    = out_valid_o && out_ready_i;

  assign col_end  = (col == CW'(IMG_W - 1));
  assign row_end  = (row == RW'(IMG_H - 1));
  assign lb_addr  = LB_AW'(col >> 1);

  // Horizontal pair max, then vertical max against the stored even-row pair
  assign m        = max_s(h, in_data_i);
  assign pooled   = max_s(pix_t'(lb_rdata), m);
  assign lb_we    = in_acc && col[0] && !row[0];
  assign load_out = in_acc && col[0] && row[0];

  pool_line_buf #(
    .DEPTH  (LB_D),
    .DATA_W (DATA_W),
    .AW     (LB_AW)
  ) u_line_buf (
    .clk   (clk_i),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (m),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // Raster position counters; frames follow each other with no gap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col <= '0;
      row <= '0;
    end else if (in_acc) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Pair register captures the even-column pixel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h <= '0;
    end else if (in_acc && !col[0]) begin
      h <= in_data_i;
    end
  end

  // Output register: a new load wins over a same-cycle handshake so valid stays high
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
    end else if (load_out) begin
      out_valid_o <= 1'b1;
      out_data_o  <= pooled;
      out_last_o  <= row_end && col_end;
    end else if (out_acc) begin
      out_valid_o <= 1'b0;
      out_last_o  <= 1'b0;
    end
  end

  // Frame-complete pulse one cycle after the last pooled pixel is taken
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_o <= 1'b0;
    end else begin
      done_o <= out_acc && out_last_o;
    end
  end

endmodule

// File: tb/tb_maxpool_2x2.sv
module tb_maxpool_2x2;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int FR = W * H;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic out_last;
  logic done;
  logic signed [DW-1:0] in_data;
  logic signed [DW-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DW-1:0] stim[$];
  logic signed [DW-1:0] exp_dat[$];
  logic signed [DW-1:0] obs_dat[$];
  bit                   exp_last[$];
  bit                   obs_last[$];
  int                   last_hs[$];
  int                   done_cyc[$];
  bit                   timeout;
  int                   stall_cycles;
  int                   stall_rdy_bad;
  int                   stall_hold_bad;

  maxpool_2x2 #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .out_last_o  (out_last),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  task automatic load_ramp(input int nframes, input int base);
    stim.delete();
    for (int f = 0; f < nframes; f++)
      for (int i = 0; i < FR; i++) stim.push_back(DW'(base + i));
  endtask

  // Drives stim, pushes the expected pooled value when the completing input is accepted,
  // and records observed output beats. Entered and left at posedge+1.
  task automatic run_stream(input int bubble_pct, input int stall_len);
    int idx, cyc, stall_rem, tail, p, r, c, b;
    bit stall_done;
    logic signed [DW-1:0] held, e;
    exp_dat.delete(); exp_last.delete(); obs_dat.delete(); obs_last.delete();
    last_hs.delete(); done_cyc.delete();
    timeout = 0; stall_cycles = 0; stall_rdy_bad = 0; stall_hold_bad = 0;
    idx = 0; cyc = 0; stall_rem = 0; tail = 0; stall_done = 0; held = '0;
    while (tail < 3) begin
      if (!stall_done && stall_len > 0 && out_valid) begin
        stall_done = 1; stall_rem = stall_len; held = out_data;
      end
      out_ready = (stall_rem == 0);
      if (idx < stim.size() && $urandom_range(99) >= bubble_pct) begin
        in_valid = 1'b1; in_data = stim[idx];
      end else begin
        in_valid = 1'b0; in_data = DW'($urandom);
      end
      @(negedge clk);
      if (stall_rem > 0) begin
        stall_cycles++;
        if (in_ready) stall_rdy_bad++;
        if (!out_valid || out_data !== held) stall_hold_bad++;
        stall_rem--;
      end
      if (out_valid && out_ready) begin
        obs_dat.push_back(out_data);
        obs_last.push_back(out_last);
        if (out_last) last_hs.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      if (in_valid && in_ready) begin
        p = idx % FR; r = p / W; c = p % W;
        if (r % 2 == 1 && c % 2 == 1) begin
          b = idx - W - 1;
          e = stim[b];
          if (stim[b+1] > e)   e = stim[b+1];
          if (stim[b+W] > e)   e = stim[b+W];
          if (stim[b+W+1] > e) e = stim[b+W+1];
          exp_dat.push_back(e);
          exp_last.push_back(r == H - 1 && c == W - 1);
        end
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
      if (idx >= stim.size() && !out_valid) tail++;
      if (cyc > 3000) begin timeout = 1; break; end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_data !== 16'sd0) begin n_fail++; $display("FAIL rst_out_data: got %0d expected 0", out_data); end
    n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b expected 0", out_last); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_idle: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_ramp;
    int k;
    logic signed [DW-1:0] ref_c[4];
    logic signed [DW-1:0] a, x;
    bit la, lx;
    ref_c = '{16'sd5, 16'sd7, 16'sd13, 16'sd15};
    load_ramp(1, 0);
    run_stream(0, 0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL ramp_timeout: got 1 expected 0"); end
    n_checks++; if (obs_dat.size() != 4) begin n_fail++; $display("FAIL ramp_count: got %0d expected 4", obs_dat.size()); end
    k = 0;
    while (obs_dat.size() > 0 && exp_dat.size() > 0) begin
      a = obs_dat.pop_front(); x = exp_dat.pop_front(); la = obs_last.pop_front(); lx = exp_last.pop_front();
      n_checks++; if (a !== x) begin n_fail++; $display("FAIL ramp_data[%0d]: got %0d expected %0d", k, a, x); end
      n_checks++; if (k < 4 && a !== ref_c[k]) begin n_fail++; $display("FAIL ramp_const[%0d]: got %0d expected %0d", k, a, ref_c[k]); end
      n_checks++; if (la !== lx) begin n_fail++; $display("FAIL ramp_last[%0d]: got %b expected %b", k, la, lx); end
      k++;
    end
    n_checks++; if (done_cyc.size() != 1 || last_hs.size() != 1) begin
      n_fail++; $display("FAIL ramp_done_count: got %0d pulses/%0d last expected 1/1", done_cyc.size(), last_hs.size());
    end else begin
      n_checks++; if (done_cyc[0] != last_hs[0] + 1) begin
        n_fail++; $display("FAIL ramp_done_time: got cycle %0d expected %0d", done_cyc[0], last_hs[0] + 1);
      end
    end
  endtask

  task automatic test_signed;
    int k;
    logic signed [DW-1:0] ref_c[4];
    logic signed [DW-1:0] a, x;
    ref_c = '{-16'sd11, -16'sd9, -16'sd3, -16'sd1};
    load_ramp(1, -16);
    run_stream(0, 0);
    n_checks++; if (timeout || obs_dat.size() != 4) begin
      n_fail++; $display("FAIL neg_count: got %0d (timeout %b) expected 4", obs_dat.size(), timeout);
    end
    k = 0;
    while (obs_dat.size() > 0 && exp_dat.size() > 0) begin
      a = obs_dat.pop_front(); x = exp_dat.pop_front();
      n_checks++; if (a !== x || (k < 4 && a !== ref_c[k])) begin
        n_fail++; $display("FAIL neg_data[%0d]: got %0d expected %0d", k, a, (k < 4) ? ref_c[k] : x);
      end
      k++;
    end
    // Mixed signs, first window fixed so a small positive must beat larger-magnitude negatives
    stim.delete();
    for (int i = 0; i < FR; i++) stim.push_back(DW'($urandom_range(2000)) - 16'sd1000);
    stim[0] = -16'sd5; stim[1] = 16'sd3; stim[W] = -16'sd700; stim[W+1] = -16'sd2;
    run_stream(0, 0);
    n_checks++; if (timeout || obs_dat.size() != 4) begin
      n_fail++; $display("FAIL mixed_count: got %0d (timeout %b) expected 4", obs_dat.size(), timeout);
    end
    n_checks++; if (obs_dat.size() > 0 && obs_dat[0] !== 16'sd3) begin
      n_fail++; $display("FAIL mixed_first: got %0d expected 3", obs_dat[0]);
    end
    k = 0;
    while (obs_dat.size() > 0 && exp_dat.size() > 0) begin
      a = obs_dat.pop_front(); x = exp_dat.pop_front();
      n_checks++; if (a !== x) begin n_fail++; $display("FAIL mixed_data[%0d]: got %0d expected %0d", k, a, x); end
      k++;
    end
  endtask

  task automatic test_backpressure;
    int k;
    logic signed [DW-1:0] a, x;
    load_ramp(1, 0);
    run_stream(0, 5);
    n_checks++; if (stall_cycles != 5) begin n_fail++; $display("FAIL bp_stall_len: got %0d expected 5", stall_cycles); end
    n_checks++; if (stall_rdy_bad != 0) begin n_fail++; $display("FAIL bp_in_ready: got %0d high cycles expected 0", stall_rdy_bad); end
    n_checks++; if (stall_hold_bad != 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", stall_hold_bad); end
    n_checks++; if (timeout || obs_dat.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d (timeout %b) expected 4", obs_dat.size(), timeout);
    end
    k = 0;
    while (obs_dat.size() > 0 && exp_dat.size() > 0) begin
      a = obs_dat.pop_front(); x = exp_dat.pop_front();
      n_checks++; if (a !== x) begin n_fail++; $display("FAIL bp_data[%0d]: got %0d expected %0d", k, a, x); end
      k++;
    end
  endtask

  task automatic test_bubbles;
    int k;
    logic signed [DW-1:0] a, x;
    bit la, lx;
    load_ramp(1, 0);
    run_stream(45, 0);
    n_checks++; if (timeout || obs_dat.size() != 4) begin
      n_fail++; $display("FAIL bub_count: got %0d (timeout %b) expected 4", obs_dat.size(), timeout);
    end
    k = 0;
    while (obs_dat.size() > 0 && exp_dat.size() > 0) begin
      a = obs_dat.pop_front(); x = exp_dat.pop_front(); la = obs_last.pop_front(); lx = exp_last.pop_front();
      n_checks++; if (a !== x || la !== lx) begin
        n_fail++; $display("FAIL bub_beat[%0d]: got %0d/%b expected %0d/%b", k, a, la, x, lx);
      end
      k++;
    end
  endtask

  task automatic test_back_to_back;
    int k;
    logic signed [DW-1:0] a, x;
    bit la, lx;
    load_ramp(2, 0);
    run_stream(0, 0);
    n_checks++; if (timeout || obs_dat.size() != 8) begin
      n_fail++; $display("FAIL b2b_count: got %0d (timeout %b) expected 8", obs_dat.size(), timeout);
    end
    k = 0;
    while (obs_dat.size() > 0 && exp_dat.size() > 0) begin
      a = obs_dat.pop_front(); x = exp_dat.pop_front(); la = obs_last.pop_front(); lx = exp_last.pop_front();
      n_checks++; if (a !== x || la !== lx) begin
        n_fail++; $display("FAIL b2b_beat[%0d]: got %0d/%b expected %0d/%b", k, a, la, x, lx);
      end
      k++;
    end
    n_checks++; if (done_cyc.size() != 2 || last_hs.size() != 2) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d pulses/%0d last expected 2/2", done_cyc.size(), last_hs.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (done_cyc[i] != last_hs[i] + 1) begin
          n_fail++; $display("FAIL b2b_done_time[%0d]: got cycle %0d expected %0d", i, done_cyc[i], last_hs[i] + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int k;
    logic signed [DW-1:0] ref_c[4];
    logic signed [DW-1:0] a;
    ref_c = '{16'sd5, 16'sd7, 16'sd13, 16'sd15};
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = DW'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'sd5) begin
      n_fail++; $display("FAIL mid_held: got valid=%b data=%0d expected 1/5", out_valid, out_data);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'sd0 || out_last !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_async_rst: got v=%b d=%0d l=%b dn=%b r=%b expected 0/0/0/0/1",
                         out_valid, out_data, out_last, done, in_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 16'sd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_rst_hold: got v=%b d=%0d r=%b expected 0/0/1", out_valid, out_data, in_ready);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    load_ramp(1, 0);
    run_stream(0, 0);
    n_checks++; if (timeout || obs_dat.size() != 4) begin
      n_fail++; $display("FAIL mid_count: got %0d (timeout %b) expected 4", obs_dat.size(), timeout);
    end
    k = 0;
    while (obs_dat.size() > 0) begin
      a = obs_dat.pop_front();
      n_checks++; if (k >= 4 || a !== ref_c[k]) begin
        n_fail++; $display("FAIL mid_data[%0d]: got %0d expected %0d", k, a, (k < 4) ? ref_c[k] : 16'sd0);
      end
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_signed();
    test_backpressure();
    test_bubbles();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
